// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared constants for the pipeline hazard controller:
//                stall FSM state encoding, register-zero id, remaining-stall
//                counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Width of the remaining-extra-stall-cycles counter
    localparam int REM_W = 1;

    // Stall FSM state encoding
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // Architectural register $zero never carries a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Extra stall cycles owed by a jr that depends on a load in EX
    localparam logic [REM_W-1:0] JR_LOAD_REM = REM_W'(1);

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_control_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at its all-ones value instead of
//                wrapping. Asynchronous active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count one per inc pulse, holding once the maximum is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_control.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control
//  Description : Pipeline hazard controller. Inserts bubbles for load-use and
//                jr-dependency hazards, squashes wrong-path fetches on taken
//                branches and jumps, and keeps saturating stall/flush counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_control
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jr,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             busy
);

    logic [0:0]       r_state;
    logic [REM_W-1:0] r_rem;

    logic             w_match;
    logic             w_load_use;
    logic             w_jr_hz;
    logic [0:0]       w_next_state;
    logic [REM_W-1:0] w_next_rem;
    logic             w_stall_inc;
    logic             w_flush_inc;

    // EX producer versus ID consumers; $zero is never a dependency
    assign w_match    = (ex_write_reg != REG_ZERO) &&
                        ((id_use_rs && (ex_write_reg == id_rs)) ||
                         (id_use_rt && (ex_write_reg == id_rt)));
    assign w_load_use = ex_mem_read && w_match;
    assign w_jr_hz    = id_jr && ex_reg_write &&
                        (ex_write_reg != REG_ZERO) && (ex_write_reg == id_rs);

    // Same-cycle pipeline control and next-state selection
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_next_state = r_state;
        w_next_rem   = r_rem;

        if (!reset) begin
            // Freeze fetch and drain both pipeline registers while in reset
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            w_next_state = ST_RUN;
            w_next_rem   = '0;
        end else if (ex_branch_taken) begin
            // Branch outcome beats any ID-side event: squash both stages once
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            w_flush_inc  = 1'b1;
            w_next_state = ST_RUN;
            w_next_rem   = '0;
        end else begin
            case (r_state)
                ST_STALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    w_stall_inc = 1'b1;
                    w_next_rem  = (r_rem != '0) ? (r_rem - REM_W'(1)) : '0;
                    if (w_next_rem == '0) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    if (w_load_use || w_jr_hz) begin
                        // Hold PC and IF/ID, bubble into EX; a pending jump
                        // is seen again once the stall clears
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        w_stall_inc = 1'b1;
                        if (w_jr_hz && ex_mem_read) begin
                            // Load data reaches the jr in ID one cycle later
                            w_next_state = ST_STALL;
                            w_next_rem   = JR_LOAD_REM;
                        end
                    end else if (id_jump || id_jr) begin
                        // Target known in ID: drop the sequential fetch
                        if_id_flush = 1'b1;
                        w_flush_inc = 1'b1;
                    end
                end
            endcase
        end
    end

    // Stall FSM registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    assign busy = (r_state == ST_STALL);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_count)
    );

endmodule : hazard_control
`default_nettype wire

// File: tb/tb_hazard_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_control
//  Description : Self-checking bench for hazard_control. A 16-bit and a
//                4-bit counter instance share stimulus; a behavioural model
//                tracks pending stall cycles and event counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, ex_write_reg;
    logic       id_use_rs, id_use_rt, id_jr, id_jump;
    logic       ex_mem_read, ex_reg_write, ex_branch_taken;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, busy;
    logic [15:0] stall_count, flush_count;
    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_flush4, busy4;
    logic [3:0]  stall_count4, flush_count4;

    int errors = 0;
    int checks = 0;

    // Model state: extra stall cycles still owed, and unbounded event counts
    int m_extra, m_stall, m_flush;
    // Model outputs for the current inputs
    logic [3:0] e_ctl;
    logic       e_busy, e_sinc, e_finc;
    int         e_next_extra;

    always #5 clk = ~clk;

    hazard_control #(.CNT_W(16)) dut (
        .clk(clk), .reset(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_jr(id_jr),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .stall_count(stall_count),
        .flush_count(flush_count), .busy(busy)
    );

    hazard_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_jr(id_jr),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
        .id_ex_flush(id_ex_flush4), .stall_count(stall_count4),
        .flush_count(flush_count4), .busy(busy4)
    );

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Reference rules: {pc_write, if_id_write, if_id_flush, id_ex_flush}
    function automatic void model_eval();
        bit dep, lu, jh;
        dep = (ex_write_reg != 5'd0) &&
              ((id_use_rs && id_rs == ex_write_reg) || (id_use_rt && id_rt == ex_write_reg));
        lu  = ex_mem_read && dep;
        jh  = id_jr && ex_reg_write && (ex_write_reg != 5'd0) && (ex_write_reg == id_rs);
        e_sinc = 1'b0;
        e_finc = 1'b0;
        e_busy = (m_extra > 0);
        e_next_extra = m_extra;
        if (!rst_n) begin
            e_ctl = 4'b0011; e_busy = 1'b0; e_next_extra = 0;
        end else if (ex_branch_taken) begin
            e_ctl = 4'b1111; e_finc = 1'b1; e_next_extra = 0;
        end else if (m_extra > 0) begin
            e_ctl = 4'b0001; e_sinc = 1'b1; e_next_extra = m_extra - 1;
        end else if (lu || jh) begin
            e_ctl = 4'b0001; e_sinc = 1'b1;
            e_next_extra = (jh && ex_mem_read) ? 1 : 0;
        end else if (id_jump || id_jr) begin
            e_ctl = 4'b1110; e_finc = 1'b1;
        end else begin
            e_ctl = 4'b1100;
        end
    endfunction

    task automatic tick();
        model_eval();
        if (rst_n) begin
            m_stall += int'(e_sinc);
            m_flush += int'(e_finc);
            m_extra  = e_next_extra;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_write_reg = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_jr = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        set_idle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = r;
        id_rs = r; id_use_rs = 1'b1;
    endtask

    task automatic set_jr_dep(input logic is_load);
        set_idle();
        id_jr = 1'b1; id_rs = 5'd31; id_use_rs = 1'b1;
        ex_mem_read = is_load; ex_reg_write = 1'b1; ex_write_reg = 5'd31;
    endtask

    function automatic logic [3:0] ctl();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush};
    endfunction

    task automatic test_reset();
        set_idle();
        #1;
        checks++;
        if (ctl() !== 4'b0011 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b busy=%b, expected ctl=0011 busy=0", ctl(), busy);
        end
        checks++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d, expected 0/0", stall_count, flush_count);
        end
        m_extra = 0; m_stall = 0; m_flush = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ctl() !== 4'b1100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ctl=%b busy=%b, expected ctl=1100 busy=0", ctl(), busy);
        end
    endtask

    task automatic test_load_use();
        int base;
        base = m_stall;
        set_load_use(5'd8);
        #1;
        checks++;
        if (ctl() !== 4'b0001) begin
            errors++;
            $display("FAIL load_use_stall: got ctl=%b, expected 0001", ctl());
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (ctl() !== 4'b1100 || int'(stall_count) !== base + 1) begin
            errors++;
            $display("FAIL load_use_after: got ctl=%b stall=%0d, expected ctl=1100 stall=%0d",
                     ctl(), stall_count, base + 1);
        end
        tick();
    endtask

    task automatic test_jr_load();
        int sbase, fbase;
        sbase = m_stall; fbase = m_flush;
        set_jr_dep(1'b1);
        #1;
        checks++;
        if (ctl() !== 4'b0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL jr_load_c1: got ctl=%b busy=%b, expected ctl=0001 busy=0", ctl(), busy);
        end
        tick();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_write_reg = 5'd0;
        #1;
        checks++;
        if (ctl() !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL jr_load_c2: got ctl=%b busy=%b, expected ctl=0001 busy=1", ctl(), busy);
        end
        tick();
        checks++;
        if (ctl() !== 4'b1110 || busy !== 1'b0 || int'(stall_count) !== sbase + 2) begin
            errors++;
            $display("FAIL jr_load_c3: got ctl=%b busy=%b stall=%0d, expected ctl=1110 busy=0 stall=%0d",
                     ctl(), busy, stall_count, sbase + 2);
        end
        tick();
        checks++;
        if (int'(flush_count) !== fbase + 1) begin
            errors++;
            $display("FAIL jr_load_flush: got flush=%0d, expected %0d", flush_count, fbase + 1);
        end
        set_idle();
    endtask

    task automatic test_jr_alu();
        int sbase, fbase;
        sbase = m_stall; fbase = m_flush;
        set_jr_dep(1'b0);
        #1;
        checks++;
        if (ctl() !== 4'b0001) begin
            errors++;
            $display("FAIL jr_alu_stall: got ctl=%b, expected 0001", ctl());
        end
        tick();
        ex_reg_write = 1'b0; ex_write_reg = 5'd0;
        #1;
        checks++;
        if (ctl() !== 4'b1110 || busy !== 1'b0) begin
            errors++;
            $display("FAIL jr_alu_redirect: got ctl=%b busy=%b, expected ctl=1110 busy=0", ctl(), busy);
        end
        tick();
        checks++;
        if (int'(stall_count) !== sbase + 1 || int'(flush_count) !== fbase + 1) begin
            errors++;
            $display("FAIL jr_alu_counts: got stall=%0d flush=%0d, expected %0d/%0d",
                     stall_count, flush_count, sbase + 1, fbase + 1);
        end
        set_idle();
    endtask

    task automatic test_branch_hazard();
        int sbase, fbase;
        sbase = m_stall; fbase = m_flush;
        set_load_use(5'd9);
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl() !== 4'b1111) begin
            errors++;
            $display("FAIL branch_over_hazard: got ctl=%b, expected 1111", ctl());
        end
        tick();
        checks++;
        if (int'(stall_count) !== sbase || int'(flush_count) !== fbase + 1) begin
            errors++;
            $display("FAIL branch_counts: got stall=%0d flush=%0d, expected %0d/%0d",
                     stall_count, flush_count, sbase, fbase + 1);
        end
        set_jr_dep(1'b1);
        tick();
        set_idle();
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl() !== 4'b1111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL branch_in_stall: got ctl=%b busy=%b, expected ctl=1111 busy=1", ctl(), busy);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (ctl() !== 4'b1100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL branch_stall_exit: got ctl=%b busy=%b, expected ctl=1100 busy=0", ctl(), busy);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        set_load_use(5'd0);
        id_rt = 5'd0; id_use_rt = 1'b1;
        #1;
        checks++;
        if (ctl() !== 4'b1100) begin
            errors++;
            $display("FAIL zero_load_use: got ctl=%b, expected 1100", ctl());
        end
        tick();
        set_jr_dep(1'b1);
        id_rs = 5'd0; ex_write_reg = 5'd0;
        #1;
        checks++;
        if (ctl() !== 4'b1110) begin
            errors++;
            $display("FAIL zero_jr: got ctl=%b, expected 1110", ctl());
        end
        tick();
        set_idle();
    endtask

    task automatic test_saturation();
        set_load_use(5'd5);
        for (int i = 0; i < 20; i++) tick();
        set_idle();
        #1;
        checks++;
        if (stall_count4 !== 4'd15 || int'(flush_count4) !== sat(m_flush, 4)) begin
            errors++;
            $display("FAIL saturation4: got stall=%0d flush=%0d, expected 15/%0d",
                     stall_count4, flush_count4, sat(m_flush, 4));
        end
        checks++;
        if (int'(stall_count) !== sat(m_stall, 16)) begin
            errors++;
            $display("FAIL saturation16: got stall=%0d, expected %0d", stall_count, sat(m_stall, 16));
        end
    endtask

    task automatic test_random();
        logic [3:0] a4;
        for (int i = 0; i < 400; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_write_reg    = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom_range(0, 1));
            id_use_rt       = 1'($urandom_range(0, 1));
            id_jr           = ($urandom_range(0, 3) == 0);
            id_jump         = ($urandom_range(0, 4) == 0);
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_reg_write    = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            #1;
            model_eval();
            a4 = {pc_write4, if_id_write4, if_id_flush4, id_ex_flush4};
            checks++;
            if (ctl() !== e_ctl || busy !== e_busy || a4 !== e_ctl || busy4 !== e_busy) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: got ctl=%b busy=%b ctl4=%b busy4=%b, expected ctl=%b busy=%b",
                         i, ctl(), busy, a4, busy4, e_ctl, e_busy);
            end
            checks++;
            if (int'(stall_count) !== sat(m_stall, 16) || int'(flush_count) !== sat(m_flush, 16) ||
                int'(stall_count4) !== sat(m_stall, 4) || int'(flush_count4) !== sat(m_flush, 4)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d %0d/%0d, expected %0d/%0d %0d/%0d",
                         i, stall_count, flush_count, stall_count4, flush_count4,
                         sat(m_stall, 16), sat(m_flush, 16), sat(m_stall, 4), sat(m_flush, 4));
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        set_jr_dep(1'b1);
        tick();
        set_idle();
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midstall_enter: got busy=%b, expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl() !== 4'b0011 || busy !== 1'b0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL midstall_reset: got ctl=%b busy=%b stall=%0d flush=%0d, expected 0011/0/0/0",
                     ctl(), busy, stall_count, flush_count);
        end
        m_extra = 0; m_stall = 0; m_flush = 0;
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl() !== 4'b1100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midstall_release: got ctl=%b busy=%b, expected ctl=1100 busy=0", ctl(), busy);
        end
        tick();
        checks++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL midstall_counts: got stall=%0d flush=%0d, expected 0/0", stall_count, flush_count);
        end
    endtask

    initial begin
        m_extra = 0; m_stall = 0; m_flush = 0;
        test_reset();
        test_load_use();
        test_jr_load();
        test_jr_alu();
        test_branch_hazard();
        test_zero_reg();
        test_saturation();
        test_random();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hazard_control
`default_nettype wire
